// File: rtl/cache_2way.sv
// Two-way set-associative, write-through / no-write-allocate L1 cache with 1-bit LRU,
// block-aligned burst refill and saturating read hit/miss counters.
module cache_2way #(
    parameter int IDX  = 6,
    parameter int OFS  = 4,
    parameter int CNTW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            PStrobe,
    input  logic            PRw,
    input  logic [31:0]     PAddress,
    input  logic [31:0]     PData_out,
    output logic [31:0]     PData_in,
    output logic            CReady,
    output logic            SysStrobe,
    output logic            SysRW,
    output logic [31:0]     SysAddress,
    output logic [31:0]     SysData_in,
    input  logic [31:0]     SysData_out,
    input  logic            SysReady,
    output logic [CNTW-1:0] HitCount,
    output logic [CNTW-1:0] MissCount
);
    localparam int TAG   = 30 - IDX - OFS;
    localparam int SETS  = 1 << IDX;
    localparam int WORDS = 1 << OFS;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

    state_t          state;
    state_t          state_next;

    logic [TAG-1:0]  tag_mem  [2][SETS];
    logic [31:0]     data_mem [2][SETS][WORDS];
    logic [SETS-1:0] valid [2];
    logic [SETS-1:0] lru;

    logic [OFS-1:0]  cnt;
    logic            victim;
    logic            sys_strobe_q;
    logic [CNTW-1:0] hit_count;
    logic [CNTW-1:0] miss_count;

    logic [OFS-1:0]  offset;
    logic [IDX-1:0]  index;
    logic [TAG-1:0]  tag;
    logic            hit0;
    logic            hit1;
    logic            hit;
    logic            hit_way;
    logic            victim_pick;
    logic            unused_addr_bits;

    assign offset           = PAddress[OFS+1:2];
    assign index            = PAddress[OFS+IDX+1:OFS+2];
    assign tag              = PAddress[31:OFS+IDX+2];
    assign unused_addr_bits = ^PAddress[1:0];

    assign hit0    = valid[0][index] && (tag_mem[0][index] == tag);
    assign hit1    = valid[1][index] && (tag_mem[1][index] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;

    // Fill empty ways first, in way order, before evicting the LRU way.
    always_comb begin
        victim_pick = lru[index];
        if (!valid[0][index]) begin
            victim_pick = 1'b0;
        end else if (!valid[1][index]) begin
            victim_pick = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (PStrobe) state_next = !PRw ? WRITE : (hit ? RESP : FILL);
            FILL:    if (SysReady && (&cnt)) state_next = RESP;
            WRITE:   if (SysReady) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        CReady     = 1'b0;
        SysRW      = 1'b0;
        SysAddress = '0;
        PData_in   = '0;
        case (state)
            FILL: begin
                SysRW      = 1'b1;
                SysAddress = {PAddress[31:OFS+2], {(OFS+2){1'b0}}};
            end
            WRITE:   SysAddress = PAddress;
            RESP: begin
                CReady   = 1'b1;
                PData_in = data_mem[hit_way][index][offset];
            end
            default: ;
        endcase
    end

    // Control state: valid/LRU bookkeeping, refill counter, bus strobe and statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid[0]     <= '0;
            valid[1]     <= '0;
            lru          <= '0;
            cnt          <= '0;
            victim       <= 1'b0;
            sys_strobe_q <= 1'b0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            sys_strobe_q <= (state == IDLE) && PStrobe && (!PRw || !hit);
            case (state)
                IDLE: begin
                    if (PStrobe && PRw) begin
                        if (hit) begin
                            lru[index] <= ~hit_way;
                            if (hit_count != '1) hit_count <= hit_count + 1'b1;
                        end else begin
                            victim <= victim_pick;
                            cnt    <= '0;
                            if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (SysReady) begin
                        cnt <= cnt + 1'b1;
                        if (&cnt) begin
                            valid[victim][index] <= 1'b1;
                            lru[index]           <= ~victim;
                        end
                    end
                end
                WRITE: begin
                    if (SysReady && hit) lru[index] <= ~hit_way;
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; an abandoned refill leaves its way invalid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == FILL && SysReady) begin
                data_mem[victim][index][cnt] <= SysData_out;
                if (&cnt) tag_mem[victim][index] <= tag;
            end
            if (state == WRITE && SysReady && hit) begin
                data_mem[hit_way][index][offset] <= PData_out;
            end
        end
    end

    assign SysStrobe  = sys_strobe_q;
    assign SysData_in = PData_out;
    assign HitCount   = hit_count;
    assign MissCount  = miss_count;
endmodule

// File: tb/tb_cache_2way.sv
// Directed bench for cache_2way: a bus responder drives each transaction and
// every scenario task compares observed timing, bus fields, data and counters.
module tb_cache_2way;
    localparam int IDX  = 6;
    localparam int OFS  = 4;
    localparam int CNTW = 4;

    logic            clock;
    logic            reset;
    logic            PStrobe;
    logic            PRw;
    logic [31:0]     PAddress;
    logic [31:0]     PData_out;
    logic [31:0]     PData_in;
    logic            CReady;
    logic            SysStrobe;
    logic            SysRW;
    logic [31:0]     SysAddress;
    logic [31:0]     SysData_in;
    logic [31:0]     SysData_out;
    logic            SysReady;
    logic [CNTW-1:0] HitCount;
    logic [CNTW-1:0] MissCount;

    int checks   = 0;
    int failures = 0;

    int          obs_lat;
    logic [31:0] obs_data;
    int          obs_strobes;
    logic [31:0] obs_addr;
    logic        obs_rw;
    logic [31:0] obs_wdata;
    logic        obs_timeout;
    int          obs_ready_after_abort;

    cache_2way #(.IDX(IDX), .OFS(OFS), .CNTW(CNTW)) dut (
        .clock      (clock),
        .reset      (reset),
        .PStrobe    (PStrobe),
        .PRw        (PRw),
        .PAddress   (PAddress),
        .PData_out  (PData_out),
        .PData_in   (PData_in),
        .CReady     (CReady),
        .SysStrobe  (SysStrobe),
        .SysRW      (SysRW),
        .SysAddress (SysAddress),
        .SysData_in (SysData_in),
        .SysData_out(SysData_out),
        .SysReady   (SysReady),
        .HitCount   (HitCount),
        .MissCount  (MissCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Runs one processor transaction starting at a negedge (cycle T). Bus words are
    // supplied as base+i, starting `delay` cycles after the strobe is seen. With
    // abort_words > 0, reset is pulsed once that many words have been delivered.
    task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] base, input int nwords, input int delay,
                           input int abort_words);
        int sent;
        int since;
        obs_lat = 0; obs_data = '0; obs_strobes = 0; obs_addr = '0; obs_rw = 1'b0;
        obs_wdata = '0; obs_timeout = 1'b1; obs_ready_after_abort = 0;
        sent = 0; since = -1;
        PStrobe = 1'b1; PRw = rw; PAddress = addr; PData_out = wdata;
        @(negedge clock);
        PStrobe = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (SysStrobe) begin
                obs_strobes++;
                obs_addr = SysAddress; obs_rw = SysRW; obs_wdata = SysData_in;
                if (since < 0) since = 0;
            end
            if (CReady) begin
                obs_lat = k; obs_data = PData_in; obs_timeout = 1'b0;
                break;
            end
            if (abort_words > 0 && sent == abort_words) begin
                SysReady = 1'b0; reset = 1'b1;
                @(negedge clock);
                if (CReady) obs_ready_after_abort++;
                reset = 1'b0;
                for (int j = 0; j < 20; j++) begin
                    @(negedge clock);
                    if (CReady) obs_ready_after_abort++;
                end
                obs_timeout = 1'b0;
                break;
            end
            if (since >= 0 && since >= delay && sent < nwords) begin
                SysReady = 1'b1; SysData_out = base + sent; sent++;
            end else begin
                SysReady = 1'b0;
            end
            if (since >= 0) since++;
            @(negedge clock);
        end
        SysReady = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (CReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_cready: got %b, expected 0", CReady); end
        checks++; if (SysStrobe !== 1'b0) begin failures++; $display("[TB] FAIL reset_sysstrobe: got %b, expected 0", SysStrobe); end
        checks++; if (SysRW !== 1'b0) begin failures++; $display("[TB] FAIL reset_sysrw: got %b, expected 0", SysRW); end
        checks++; if (SysAddress !== 32'h0) begin failures++; $display("[TB] FAIL reset_sysaddress: got %h, expected 0", SysAddress); end
        checks++; if (PData_in !== 32'h0) begin failures++; $display("[TB] FAIL reset_pdata_in: got %h, expected 0", PData_in); end
        checks++; if (HitCount !== 4'd0) begin failures++; $display("[TB] FAIL reset_hitcount: got %0d, expected 0", HitCount); end
        checks++; if (MissCount !== 4'd0) begin failures++; $display("[TB] FAIL reset_misscount: got %0d, expected 0", MissCount); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_cold_miss();
        run_txn(1'b1, 32'h0000_1040, 32'h0, 32'hA0, 16, 0, 0);
        checks++; if (obs_timeout) begin failures++; $display("[TB] FAIL cold_timeout: got no CReady, expected CReady"); end
        checks++; if (obs_lat !== 17) begin failures++; $display("[TB] FAIL cold_latency: got %0d, expected 17", obs_lat); end
        checks++; if (obs_strobes !== 1) begin failures++; $display("[TB] FAIL cold_strobes: got %0d, expected 1", obs_strobes); end
        checks++; if (obs_addr !== 32'h0000_1040) begin failures++; $display("[TB] FAIL cold_sysaddress: got %h, expected 00001040", obs_addr); end
        checks++; if (obs_rw !== 1'b1) begin failures++; $display("[TB] FAIL cold_sysrw: got %b, expected 1", obs_rw); end
        checks++; if (obs_data !== 32'hA0) begin failures++; $display("[TB] FAIL cold_data: got %h, expected a0", obs_data); end
        checks++; if (MissCount !== 4'd1) begin failures++; $display("[TB] FAIL cold_misscount: got %0d, expected 1", MissCount); end
    endtask

    task automatic test_read_hit();
        run_txn(1'b1, 32'h0000_1044, 32'h0, 32'h0, 16, 0, 0);
        checks++; if (obs_lat !== 1) begin failures++; $display("[TB] FAIL hit_latency: got %0d, expected 1", obs_lat); end
        checks++; if (obs_strobes !== 0) begin failures++; $display("[TB] FAIL hit_strobes: got %0d, expected 0", obs_strobes); end
        checks++; if (obs_data !== 32'hA1) begin failures++; $display("[TB] FAIL hit_data: got %h, expected a1", obs_data); end
        checks++; if (HitCount !== 4'd1) begin failures++; $display("[TB] FAIL hit_hitcount: got %0d, expected 1", HitCount); end
    endtask

    task automatic test_lru_conflict();
        run_txn(1'b1, 32'h0000_2040, 32'h0, 32'hB0, 16, 2, 0);
        checks++; if (obs_lat !== 19) begin failures++; $display("[TB] FAIL lru_fill_b_latency: got %0d, expected 19", obs_lat); end
        checks++; if (obs_data !== 32'hB0) begin failures++; $display("[TB] FAIL lru_fill_b_data: got %h, expected b0", obs_data); end
        run_txn(1'b1, 32'h0000_1040, 32'h0, 32'h0, 16, 0, 0);
        checks++; if (obs_lat !== 1) begin failures++; $display("[TB] FAIL lru_a_hit1: got latency %0d, expected 1", obs_lat); end
        run_txn(1'b1, 32'h0000_3040, 32'h0, 32'hC0, 16, 0, 0);
        checks++; if (obs_lat !== 17) begin failures++; $display("[TB] FAIL lru_c_miss: got latency %0d, expected 17", obs_lat); end
        checks++; if (obs_data !== 32'hC0) begin failures++; $display("[TB] FAIL lru_c_data: got %h, expected c0", obs_data); end
        run_txn(1'b1, 32'h0000_1040, 32'h0, 32'h0, 16, 0, 0);
        checks++; if (obs_lat !== 1) begin failures++; $display("[TB] FAIL lru_a_hit2: got latency %0d, expected 1", obs_lat); end
        run_txn(1'b1, 32'h0000_2040, 32'h0, 32'hB8, 16, 0, 0);
        checks++; if (obs_lat !== 17) begin failures++; $display("[TB] FAIL lru_b_evicted: got latency %0d, expected 17", obs_lat); end
        checks++; if (obs_data !== 32'hB8) begin failures++; $display("[TB] FAIL lru_b_refill_data: got %h, expected b8", obs_data); end
        run_txn(1'b1, 32'h0000_1040, 32'h0, 32'h0, 16, 0, 0);
        checks++; if (obs_lat !== 1) begin failures++; $display("[TB] FAIL lru_a_hit3: got latency %0d, expected 1", obs_lat); end
        checks++; if (obs_data !== 32'hA0) begin failures++; $display("[TB] FAIL lru_a_data: got %h, expected a0", obs_data); end
        checks++; if (HitCount !== 4'd4) begin failures++; $display("[TB] FAIL lru_hitcount: got %0d, expected 4", HitCount); end
        checks++; if (MissCount !== 4'd4) begin failures++; $display("[TB] FAIL lru_misscount: got %0d, expected 4", MissCount); end
    endtask

    task automatic test_write_hit();
        run_txn(1'b0, 32'h0000_1048, 32'hDEAD_BEEF, 32'h0, 1, 3, 0);
        checks++; if (obs_lat !== 5) begin failures++; $display("[TB] FAIL wr_hit_latency: got %0d, expected 5", obs_lat); end
        checks++; if (obs_strobes !== 1) begin failures++; $display("[TB] FAIL wr_hit_strobes: got %0d, expected 1", obs_strobes); end
        checks++; if (obs_rw !== 1'b0) begin failures++; $display("[TB] FAIL wr_hit_sysrw: got %b, expected 0", obs_rw); end
        checks++; if (obs_addr !== 32'h0000_1048) begin failures++; $display("[TB] FAIL wr_hit_sysaddress: got %h, expected 00001048", obs_addr); end
        checks++; if (obs_wdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL wr_hit_sysdata: got %h, expected deadbeef", obs_wdata); end
        run_txn(1'b1, 32'h0000_1048, 32'h0, 32'h0, 16, 0, 0);
        checks++; if (obs_lat !== 1 || obs_strobes !== 0) begin failures++; $display("[TB] FAIL wr_hit_readback_hit: got latency %0d strobes %0d, expected 1 and 0", obs_lat, obs_strobes); end
        checks++; if (obs_data !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL wr_hit_readback_data: got %h, expected deadbeef", obs_data); end
        run_txn(1'b1, 32'h0000_104C, 32'h0, 32'h0, 16, 0, 0);
        checks++; if (obs_data !== 32'hA3) begin failures++; $display("[TB] FAIL wr_hit_neighbour: got %h, expected a3", obs_data); end
    endtask

    task automatic test_write_miss();
        run_txn(1'b0, 32'h0000_5000, 32'h1234_5678, 32'h0, 1, 0, 0);
        checks++; if (obs_lat !== 2) begin failures++; $display("[TB] FAIL wr_miss_latency: got %0d, expected 2", obs_lat); end
        checks++; if (obs_addr !== 32'h0000_5000 || obs_rw !== 1'b0) begin failures++; $display("[TB] FAIL wr_miss_bus: got addr %h rw %b, expected 00005000 and 0", obs_addr, obs_rw); end
        checks++; if (HitCount !== 4'd6 || MissCount !== 4'd4) begin failures++; $display("[TB] FAIL wr_counters: got hits %0d misses %0d, expected 6 and 4", HitCount, MissCount); end
        run_txn(1'b1, 32'h0000_5000, 32'h0, 32'hE0, 16, 0, 0);
        checks++; if (obs_lat !== 17 || obs_strobes !== 1) begin failures++; $display("[TB] FAIL wr_miss_no_allocate: got latency %0d strobes %0d, expected 17 and 1", obs_lat, obs_strobes); end
        checks++; if (obs_data !== 32'hE0) begin failures++; $display("[TB] FAIL wr_miss_read_data: got %h, expected e0", obs_data); end
        checks++; if (MissCount !== 4'd5) begin failures++; $display("[TB] FAIL wr_miss_misscount: got %0d, expected 5", MissCount); end
    endtask

    task automatic test_reset_during_fill();
        run_txn(1'b1, 32'h0000_9080, 32'h0, 32'h90, 16, 0, 5);
        checks++; if (obs_ready_after_abort !== 0) begin failures++; $display("[TB] FAIL abort_cready: got %0d pulses, expected 0", obs_ready_after_abort); end
        checks++; if (HitCount !== 4'd0 || MissCount !== 4'd0) begin failures++; $display("[TB] FAIL abort_counters: got hits %0d misses %0d, expected 0 and 0", HitCount, MissCount); end
        run_txn(1'b1, 32'h0000_9080, 32'h0, 32'h90, 16, 0, 0);
        checks++; if (obs_lat !== 17) begin failures++; $display("[TB] FAIL abort_reread_miss: got latency %0d, expected 17", obs_lat); end
        checks++; if (obs_data !== 32'h90) begin failures++; $display("[TB] FAIL abort_reread_data: got %h, expected 90", obs_data); end
        run_txn(1'b1, 32'h0000_1040, 32'h0, 32'hF0, 16, 0, 0);
        checks++; if (obs_lat !== 17 || obs_data !== 32'hF0) begin failures++; $display("[TB] FAIL abort_valid_cleared: got latency %0d data %h, expected 17 and f0", obs_lat, obs_data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expected;
        for (int i = 1; i <= 3; i++) begin
            expected = 32'h90 + i;
            run_txn(1'b1, 32'h0000_9080 + 4 * i, 32'h0, 32'h0, 16, 0, 0);
            checks++; if (obs_lat !== 1 || obs_data !== expected) begin failures++; $display("[TB] FAIL b2b_word%0d: got latency %0d data %h, expected 1 and %h", i, obs_lat, obs_data, expected); end
        end
        checks++; if (HitCount !== 4'd3 || MissCount !== 4'd2) begin failures++; $display("[TB] FAIL b2b_counters: got hits %0d misses %0d, expected 3 and 2", HitCount, MissCount); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 16; i++) begin
            run_txn(1'b1, 32'h0000_9084, 32'h0, 32'h0, 16, 0, 0);
        end
        checks++; if (HitCount !== 4'd15) begin failures++; $display("[TB] FAIL sat_hitcount: got %0d, expected 15", HitCount); end
        checks++; if (MissCount !== 4'd2) begin failures++; $display("[TB] FAIL sat_misscount: got %0d, expected 2", MissCount); end
    endtask

    initial begin
        reset = 1'b1; PStrobe = 1'b0; PRw = 1'b1; PAddress = '0; PData_out = '0;
        SysReady = 1'b0; SysData_out = '0;
        test_reset();
        test_cold_miss();
        test_read_hit();
        test_lru_conflict();
        test_write_hit();
        test_write_miss();
        test_reset_during_fill();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
